oric_key_matrix: RTL
====================

ORIC_KEY_MATRIX -- requirements
Module: oric_key_matrix

Interface
REQ-001 Parameter: NMI_CODE, 8'h07, set-2 scan code (non-extended) driving nmi_n instead of the matrix.
REQ-002 clk_i  in  1  system clock (24 MHz core clock).
REQ-003 res_n_i  in  1  reset, asynchronous, active-low.
REQ-004 key_strobe  in  1  one-cycle pulse; key_pressed/key_extended/key_code are valid in that cycle.
REQ-005 key_pressed  in  1  1=make, 0=break.
REQ-006 key_extended  in  1  E0-prefixed scan code.
REQ-007 key_code  in  8  PS/2 set-2 scan code.
REQ-008 row_sel  in  3  matrix row select (VIA PB2..0).
REQ-009 col_mask  in  8  active-low column enables (PSG port A); bit n low selects column n.
REQ-010 key_hit  out  1  high when any held key lies in row_sel under an enabled column (VIA PB3).
REQ-011 nmi_n  out  1  low while NMI_CODE is held.
REQ-012 matrix_busy  out  1  high while any event is in the pipeline.

Function
REQ-013 Event pipeline, three stages, fully pipelined: S0 latch {pressed, extended, code} on key_strobe; S1 synchronous ROM lookup, address {extended, code}; S2 matrix update.
REQ-014 Accept one event per cycle; back-to-back strobes apply in arrival order, none dropped.
REQ-015 ROM entry: {valid, row[2:0], col[2:0]}; valid=0 -> event discarded, matrix unchanged.
REQ-016 S2: make sets matrix[row][col], break clears it; repeated make (typematic) is idempotent.
REQ-017 Non-extended NMI_CODE bypasses ROM: make drives nmi_n=0, break drives nmi_n=1, in the cycle the event reaches S2.
REQ-018 Matrix state update visible 3 cycles after key_strobe (strobe at cycle t -> matrix bit at t+3).
REQ-019 key_hit registered: key_hit(t+1) = OR over n of (matrix[row_sel(t)][n] AND NOT col_mask(t)[n]).
REQ-020 Make and break for the same key in S1/S2 on consecutive cycles: final bit equals the later event.
REQ-021 S2 write and key_hit read of the same bit in one cycle: key_hit reflects the pre-write value; post-write value next cycle.
REQ-022 col_mask=8'hFF -> key_hit=0 regardless of matrix.
REQ-023 matrix_busy = OR of S0/S1 valid flags; low in idle.
REQ-024 Left and right shift map to distinct bits (0x12 -> row 4 col 4; 0x59 -> row 7 col 4).
REQ-025 Reference ROM entries: 0x1C -> row 6 col 5; E0+0x75 -> row 4 col 3; 0x29 (space) -> row 4 col 0.

Reset
REQ-026 res_n_i low asynchronously clears all 64 matrix bits, pipeline valid flags, key_hit=0, nmi_n=1, matrix_busy=0.
REQ-027 Events in flight at reset are discarded; first strobe after release is handled normally.
REQ-028 Reset release synchronised internally (two-flop) before deasserting internal clear.

Structure
REQ-029 Package oric_kbd_pkg: key_event_t struct, rom_entry_t struct, ROW_W/COL_W constants, default NMI_CODE.
REQ-030 Sub-module oric_key_rom: 512x7 synchronous ROM, one-cycle read latency, table from package-defined init.
REQ-031 Matrix held as 8x8 flop array, no RAM inference.

Verification
REQ-032 Strobe make 0x1C, row_sel=6, col_mask=8'hDF -> key_hit=1 at t+4; break 0x1C -> key_hit=0 four cycles after break strobe.
REQ-033 Make 0x12 and make 0x59 on consecutive cycles, break 0x12 -> row 4 col 4 clear, row 7 col 4 still set.
REQ-034 Make E0/0x75, row_sel=4, col_mask=8'hF7 -> key_hit=1; same code non-extended (keypad 8 unmapped) -> no change.
REQ-035 Make 0x07 -> nmi_n=0 at t+3, matrix unchanged; break -> nmi_n=1.
REQ-036 Make 0x29 then assert res_n_i low mid-pipeline -> all matrix bits 0, key_hit=0, nmi_n=1, busy=0 immediately.
REQ-037 Make 0x1C held, col_mask=8'hFF -> key_hit=0; random event stream checked against a reference matrix model.

Source files
------------

// File: rtl/oric_kbd_pkg.sv
// Shared types and the PS/2 set-2 to Oric 8x8 matrix translation table.
package oric_kbd_pkg;

  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 3;
  localparam logic [7:0] DEF_NMI_CODE = 8'h07;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } rom_entry_t;

  function automatic rom_entry_t ent(input int unsigned r, input int unsigned c);
    return '{valid: 1'b1, row: ROW_W'(r), col: COL_W'(c)};
  endfunction

  // Address is {extended, code}; E0-prefixed codes live in the upper half.
  function automatic rom_entry_t rom_init(input logic [8:0] addr);
    rom_entry_t e;
    e = '0;
    case (addr)
      9'h03D: e = ent(0, 0);  9'h031: e = ent(0, 1);  9'h02E: e = ent(0, 2);
      9'h02A: e = ent(0, 3);  9'h016: e = ent(0, 5);  9'h022: e = ent(0, 6);
      9'h026: e = ent(0, 7);
      9'h03B: e = ent(1, 0);  9'h02C: e = ent(1, 1);  9'h02D: e = ent(1, 2);
      9'h02B: e = ent(1, 3);  9'h076: e = ent(1, 5);  9'h015: e = ent(1, 6);
      9'h023: e = ent(1, 7);
      9'h03A: e = ent(2, 0);  9'h036: e = ent(2, 1);  9'h032: e = ent(2, 2);
      9'h025: e = ent(2, 3);  9'h014: e = ent(2, 4);  9'h114: e = ent(2, 4);
      9'h01A: e = ent(2, 5);  9'h01E: e = ent(2, 6);  9'h021: e = ent(2, 7);
      9'h042: e = ent(3, 0);  9'h046: e = ent(3, 1);  9'h04C: e = ent(3, 2);
      9'h04E: e = ent(3, 3);  9'h05D: e = ent(3, 6);  9'h052: e = ent(3, 7);
      9'h029: e = ent(4, 0);  9'h041: e = ent(4, 1);  9'h049: e = ent(4, 2);
      9'h175: e = ent(4, 3);  9'h012: e = ent(4, 4);  9'h16B: e = ent(4, 5);
      9'h172: e = ent(4, 6);  9'h174: e = ent(4, 7);
      9'h03C: e = ent(5, 0);  9'h043: e = ent(5, 1);  9'h044: e = ent(5, 2);
      9'h04D: e = ent(5, 3);  9'h066: e = ent(5, 5);  9'h05B: e = ent(5, 6);
      9'h054: e = ent(5, 7);
      9'h035: e = ent(6, 0);  9'h033: e = ent(6, 1);  9'h034: e = ent(6, 2);
      9'h024: e = ent(6, 3);  9'h01C: e = ent(6, 5);  9'h01B: e = ent(6, 6);
      9'h01D: e = ent(6, 7);
      9'h03E: e = ent(7, 0);  9'h04B: e = ent(7, 1);  9'h045: e = ent(7, 2);
      9'h04A: e = ent(7, 3);  9'h059: e = ent(7, 4);  9'h05A: e = ent(7, 5);
      9'h055: e = ent(7, 7);
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/oric_key_rom.sv
// 512x7 synchronous translation ROM, one-cycle read latency.
module oric_key_rom
  import oric_kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic [8:0] addr,
  output rom_entry_t data
);

  always_ff @(posedge clk_i) begin
    data <= rom_init(addr);
  end

endmodule

// File: rtl/oric_key_matrix.sv
// PS/2 key events to Oric keyboard matrix: latch, ROM translate, then update an 8x8 flop array
// that the VIA row select and PSG column mask scan.
module oric_key_matrix
  import oric_kbd_pkg::*;
#(
  parameter logic [7:0] NMI_CODE = DEF_NMI_CODE
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic       key_extended,
  input  logic [7:0] key_code,
  input  logic [2:0] row_sel,
  input  logic [7:0] col_mask,
  output logic       key_hit,
  output logic       nmi_n,
  output logic       matrix_busy
);

  // Asynchronous assert, release aligned to clk_i after two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  key_event_t      s0_ev_q;
  logic            s0_valid_q;
  logic            s1_valid_q;
  logic            s1_pressed_q;
  logic            s1_nmi_q;
  rom_entry_t      s1_entry;
  logic [7:0][7:0] matrix_q;
  logic            nmi_n_q;
  logic            key_hit_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_ev_q    <= '0;
    end else begin
      s0_valid_q <= key_strobe;
      if (key_strobe) begin
        s0_ev_q <= '{pressed: key_pressed, extended: key_extended, code: key_code};
      end
    end
  end

  oric_key_rom u_rom (
    .clk_i (clk_i),
    .addr  ({s0_ev_q.extended, s0_ev_q.code}),
    .data  (s1_entry)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_pressed_q <= 1'b0;
      s1_nmi_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s0_valid_q;
      s1_pressed_q <= s0_ev_q.pressed;
      s1_nmi_q     <= !s0_ev_q.extended && (s0_ev_q.code == NMI_CODE);
    end
  end

  // The NMI key never touches the matrix, whatever the ROM says about it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      matrix_q <= '0;
      nmi_n_q  <= 1'b1;
    end else if (s1_valid_q) begin
      if (s1_nmi_q) begin
        nmi_n_q <= !s1_pressed_q;
      end else if (s1_entry.valid) begin
        matrix_q[s1_entry.row][s1_entry.col] <= s1_pressed_q;
      end
    end
  end

  // Reads the matrix as it stood before any write on the same edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) key_hit_q <= 1'b0;
    else        key_hit_q <= |(matrix_q[row_sel] & ~col_mask);
  end

  assign key_hit     = key_hit_q;
  assign nmi_n       = nmi_n_q;
  assign matrix_busy = s0_valid_q | s1_valid_q;

endmodule
